// File: rtl/delay_line_vector_if.sv
// Sample-stream bundle for delay_line_vector: control, input sample and tapped output.
// The master side drives stimulus and the slave side (the delay line) drives the tap outputs.
interface delay_line_vector_if #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_BITS = 4
);
   logic                  enable;
   logic                  clear;
   logic [DEPTH_BITS-1:0] depth_sel;
   logic                  valid_in;
   logic [WIDTH-1:0]      data_in;
   logic                  valid_out;
   logic [WIDTH-1:0]      data_out;
   logic                  busy;

   modport master (
      output enable, clear, depth_sel, valid_in, data_in,
      input  valid_out, data_out, busy
   );

   modport slave (
      input  enable, clear, depth_sel, valid_in, data_in,
      output valid_out, data_out, busy
   );
endinterface

// File: rtl/delay_line_vector.sv
// Programmable-tap delay line: latency depth_reg+1 enabled edges, no backpressure (enable stalls all state).
// A tap change flushes in-flight samples and holds valid_out low (busy) for depth_reg+1 enabled edges.
module delay_line_vector #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   delay_line_vector_if.slave    bus
);
   localparam int MAX_DEPTH = 2 ** DEPTH_BITS;

   typedef enum logic {
      RUN    = 1'b0,
      RESYNC = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DEPTH_BITS:0]   cnt;
   logic [DEPTH_BITS:0]   cnt_nxt;
   logic [DEPTH_BITS-1:0] depth_reg;
   logic [WIDTH-1:0]      s_data [MAX_DEPTH];
   logic [MAX_DEPTH-1:0]  s_valid;
   logic                  depth_chg;

   assign depth_chg = (bus.depth_sel != depth_reg);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (depth_chg) begin
         state_nxt = RESYNC;
         cnt_nxt   = '0;
      end else if (state == RESYNC && bus.enable) begin
         if (cnt == {1'b0, depth_reg}) begin
            state_nxt = RUN;
         end else begin
            cnt_nxt = cnt + {{DEPTH_BITS{1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         cnt       <= '0;
         depth_reg <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (depth_chg) begin
            depth_reg <= bus.depth_sel;
         end
      end
   end

   // Data never flushes; only the valid bits carry ownership of a sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < MAX_DEPTH; k++) begin
            s_data[k] <= '0;
         end
      end else if (bus.enable) begin
         s_data[0] <= bus.data_in;
         for (int k = 1; k < MAX_DEPTH; k++) begin
            s_data[k] <= s_data[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_valid <= '0;
      end else if (depth_chg || bus.clear) begin
         s_valid <= '0;
      end else if (bus.enable) begin
         s_valid <= {s_valid[MAX_DEPTH-2:0], bus.valid_in};
      end
   end

   assign bus.data_out  = s_data[depth_reg];
   assign bus.valid_out = s_valid[depth_reg] && (state == RUN);
   assign bus.busy      = (state == RESYNC);
endmodule

// File: tb/tb_delay_line_vector.sv
// Scoreboard bench for delay_line_vector: each accepted sample is queued with the enabled-edge
// index at which it must appear; tap changes, clears and resets discard the queue.
module tb_delay_line_vector;
   localparam int W  = 8;
   localparam int DB = 4;

   typedef struct {
      logic [W-1:0] dat;
      int           due;
   } exp_t;

   logic clk;
   logic reset;
   delay_line_vector_if #(.WIDTH(W), .DEPTH_BITS(DB)) bus ();

   delay_line_vector #(.WIDTH(W), .DEPTH_BITS(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t          q[$];
   int            checks   = 0;
   int            failures = 0;
   int            n        = 0;
   int            busy_rem = 0;
   logic [DB-1:0] cur_depth = '0;
   logic          exp_vld  = 1'b0;
   logic [W-1:0]  exp_dat  = '0;
   logic [W-1:0]  seq_dat  = 8'h01;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic en, input logic clr, input logic vin,
                       input logic [W-1:0] din, input logic [DB-1:0] dsel);
      bus.enable    = en;
      bus.clear     = clr;
      bus.valid_in  = vin;
      bus.data_in   = din;
      bus.depth_sel = dsel;
      @(posedge clk);
      if (en) n++;
      if (dsel != cur_depth) begin
         q.delete();
         cur_depth = dsel;
         busy_rem  = int'(dsel) + 1;
         exp_vld   = 1'b0;
      end else begin
         if (en && busy_rem > 0) busy_rem--;
         if (clr) begin
            q.delete();
            exp_vld = 1'b0;
         end
         if (en && vin && !clr) q.push_back('{dat: din, due: n + int'(cur_depth)});
         if (en && !clr) begin
            if (q.size() > 0 && q[0].due == n) begin
               exp_vld = 1'b1;
               exp_dat = q[0].dat;
               void'(q.pop_front());
            end else begin
               exp_vld = 1'b0;
            end
         end
      end
      @(negedge clk);
      chk("valid_out", 32'(bus.valid_out), 32'(exp_vld));
      if (exp_vld) chk("data_out", 32'(bus.data_out), 32'(exp_dat));
      chk("busy", 32'(bus.busy), 32'(busy_rem > 0));
   endtask

   task automatic stream(input int cnt, input logic [DB-1:0] dsel);
      for (int i = 0; i < cnt; i++) begin
         step(1'b1, 1'b0, 1'b1, seq_dat, dsel);
         seq_dat = seq_dat + 8'h01;
      end
   endtask

   task automatic idle(input int cnt, input logic [DB-1:0] dsel);
      for (int i = 0; i < cnt; i++) step(1'b1, 1'b0, 1'b0, 8'h00, dsel);
   endtask

   // Asserted between edges so the output drop cannot come from a clock edge.
   task automatic do_reset(input logic [DB-1:0] dsel_release);
      #2 reset = 1'b1;
      #1;
      q.delete();
      cur_depth = '0;
      busy_rem  = 0;
      exp_vld   = 1'b0;
      exp_dat   = '0;
      chk("rst_async_vld", 32'(bus.valid_out), 32'd0);
      chk("rst_async_dat", 32'(bus.data_out), 32'd0);
      chk("rst_async_busy", 32'(bus.busy), 32'd0);
      bus.depth_sel = dsel_release;
      @(negedge clk);
      @(negedge clk);
      chk("rst_hold_vld", 32'(bus.valid_out), 32'd0);
      chk("rst_hold_dat", 32'(bus.data_out), 32'd0);
      chk("rst_hold_busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.enable    = 1'b0;
      bus.clear     = 1'b0;
      bus.valid_in  = 1'b0;
      bus.data_in   = '0;
      bus.depth_sel = '0;
      @(negedge clk);
      do_reset(4'd0);

      // Fixed depth 3: entry edge, then 0x01.. streamed.
      step(1'b1, 1'b0, 1'b0, 8'h00, 4'd3);
      stream(12, 4'd3);
      idle(5, 4'd3);

      // Depth 2 with enable toggling.
      idle(4, 4'd2);
      for (int i = 0; i < 16; i++) begin
         step(1'(i % 2 == 0), 1'b0, 1'b1, seq_dat, 4'd2);
         seq_dat = seq_dat + 8'h01;
      end
      idle(4, 4'd2);

      // Stream at 5, switch to 1 mid-stream.
      stream(10, 4'd5);
      stream(10, 4'd1);
      idle(3, 4'd1);

      // Clear pulse while streaming at depth 4.
      stream(8, 4'd4);
      step(1'b1, 1'b1, 1'b1, 8'h5A, 4'd4);
      stream(8, 4'd4);
      idle(6, 4'd4);

      // Deepest and shallowest taps.
      idle(17, 4'd15);
      step(1'b1, 1'b0, 1'b1, 8'hAA, 4'd15);
      idle(18, 4'd15);
      idle(2, 4'd0);
      step(1'b1, 1'b0, 1'b1, 8'h55, 4'd0);
      idle(2, 4'd0);

      // Async reset in the middle of a resync with valid data in flight.
      stream(8, 4'd6);
      stream(3, 4'd9);
      do_reset(4'd0);
      step(1'b1, 1'b0, 1'b1, 8'hC3, 4'd0);
      idle(2, 4'd0);

      // Reset release with a nonzero tap enters resync on the first edge.
      do_reset(4'd2);
      stream(6, 4'd2);
      idle(3, 4'd2);

      // Random traffic.
      begin
         logic [DB-1:0] d;
         d = 4'd2;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) d = DB'($urandom_range(0, 15));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), W'($urandom), d);
         end
         idle(20, d);
      end
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/delay_line_vector.md
DELAY_LINE_VECTOR -- requirements
Module: delay_line_vector

Interface
REQ-001 Parameter WIDTH, default 8, data bits per sample.
REQ-002 Parameter DEPTH_BITS, default 4, width of depth_sel. MAX_DEPTH = 2**DEPTH_BITS stages, DEPTH_BITS >= 1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  shift enable; pipeline, valid bits and resync counter advance only when high.
REQ-006 clear  input  1  synchronous flush of all valid bits.
REQ-007 depth_sel  input  DEPTH_BITS  requested latency minus one; value d selects d+1 enabled cycles.
REQ-008 valid_in  input  1  qualifies data_in.
REQ-009 data_in  input  WIDTH  sample entering stage 0.
REQ-010 valid_out  output  1  qualifies data_out.
REQ-011 data_out  output  WIDTH  sample at selected tap.
REQ-012 busy  output  1  high while in RESYNC state.

Function
REQ-013 Storage: MAX_DEPTH data stages s_data[0..MAX_DEPTH-1] and parallel valid bits s_valid[0..MAX_DEPTH-1].
REQ-014 Enabled edge: s_data[0]<=data_in, s_valid[0]<=valid_in, stage k<=stage k-1 for k>=1. Enable low: all stages hold.
REQ-015 depth_reg (DEPTH_BITS) holds active tap. data_out = s_data[depth_reg], combinational from registers.
REQ-016 Output validity: valid_out = s_valid[depth_reg] AND state==RUN.
REQ-017 Latency: sample presented with valid_in=1 on enabled edge E appears at data_out with valid_out=1 after E plus depth_reg further enabled edges, i.e. depth_reg+1 enabled edges total, depth unchanged.
REQ-018 Data width is preserved bit-exact; no arithmetic on data.
REQ-019 States: RUN, RESYNC. 5-bit-wide-enough counter cnt (DEPTH_BITS+1 bits).
REQ-020 Depth change: any edge with depth_sel != depth_reg loads depth_reg<=depth_sel, clears all s_valid, cnt<=0, state<=RESYNC, regardless of enable and current state.
REQ-021 Re-entry: depth change while in RESYNC restarts cnt at 0 with the new depth.
REQ-022 RESYNC, no depth change, enabled edge: if cnt==depth_reg then state<=RUN, else cnt<=cnt+1. Shifting continues normally during RESYNC.
REQ-023 RESYNC duration: exactly depth_reg+1 enabled edges after entry edge. valid_out stays 0 throughout.
REQ-024 clear=1: all s_valid<=0 on that edge, overriding the shift of valid bits. Data stages still shift if enable=1. State, cnt and depth_reg unaffected.
REQ-025 clear and depth change on same edge: depth-change behaviour (REQ-020) applies. Result is identical flush.
REQ-026 No sample emitted twice or reordered across a depth change. Samples in flight at change are discarded.
REQ-027 MAX_DEPTH tap (depth_sel all ones) is legal. depth_sel 0 gives 1-cycle latency.

Reset
REQ-028 reset=1 asynchronously forces all s_data to 0, all s_valid to 0, depth_reg to 0, cnt to 0, state to RUN.
REQ-029 During and immediately after reset: valid_out=0, data_out=0, busy=0.
REQ-030 If depth_sel != 0 at reset release, first edge enters RESYNC per REQ-020.
REQ-031 Reset asserted mid-RESYNC or mid-stream discards all in-flight samples. No state survives.

Verification
REQ-032 Fixed depth: depth_sel=3, enable=1, valid_in=1 with data 0x01,0x02,... after RESYNC completes -> 0x01 at valid_out=1 exactly 4 edges after entry, then one per cycle in order.
REQ-033 Enable gaps: depth_sel=2, enable toggled 1,0,1,0 -> data_out/valid_out hold on disabled edges, and a sample emerges after exactly 3 enabled edges.
REQ-034 Depth change: streaming at depth_sel=5, switch to depth_sel=1 -> busy=1 for exactly 2 enabled edges, valid_out=0 during them, then the first sample entered after the change emerges. No pre-change sample appears.
REQ-035 Clear: streaming at depth_sel=4, pulse clear for 1 cycle -> valid_out=0 for next 5 enabled cycles, busy stays 0, depth_reg unchanged.
REQ-036 Boundary: depth_sel=15 (DEPTH_BITS=4), single valid 0xAA -> emerges after exactly 16 enabled edges. depth_sel=0 -> emerges after 1.
REQ-037 Async reset mid-RESYNC with valid data in pipe -> outputs 0 immediately without clock edge, busy=0, and after release with depth_sel=0 the first valid sample emerges after 1 enabled edge.
